// File: rtl/pe_pkg.sv
// Shared PE-array definitions: packet layout, type codes and network addresses.
// The packet struct overlays the 47-bit packetizer word, MSB first.
package pe_pkg;

  localparam int PKT_W    = 47;
  localparam int DEST_LSB = 43;
  localparam int DEST_W   = 4;
  localparam int SRC_LSB  = 39;
  localparam int SRC_W    = 4;
  localparam int TYPE_LSB = 37;
  localparam int TYPE_W   = 2;
  localparam int COL_LSB  = 16;
  localparam int COL_W    = 5;
  localparam int PSUM_LSB = 0;
  localparam int PSUM_W   = 16;

  localparam logic [TYPE_W-1:0] PKT_PSUM   = 2'b10;
  localparam logic [TYPE_W-1:0] PKT_FILTER = 2'b01;

  localparam logic [DEST_W-1:0] COLLECTOR_ADDR = 4'hF;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [SRC_W-1:0]  src;
    logic [TYPE_W-1:0] ptype;
    logic [15:0]       rsvd;
    logic [COL_W-1:0]  col;
    logic [PSUM_W-1:0] psum;
  } psum_pkt_t;

  function automatic psum_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
    return psum_pkt_t'(raw);
  endfunction

endpackage

// File: rtl/psum_col_slot.sv
// One output-column accumulator: running partial sum plus a per-PE contribution mask.
// full_o flags the add that completes the mask; sum_o is the sum including this cycle's add.
module psum_col_slot
  import pe_pkg::*;
#(
  parameter int PSWIDTH = 16,
  parameter int NUM_PE  = 3,
  parameter int SW      = PSWIDTH + $clog2(NUM_PE) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               add_en_i,
  input  logic               clear_i,
  input  logic [SRC_W-1:0]   src_i,
  input  logic [PSWIDTH-1:0] psum_i,
  output logic               full_o,
  output logic               dup_o,
  output logic [SW-1:0]      sum_o
);

  logic [NUM_PE-1:0] mask_q, mask_d, src_oh_s;
  logic [SW-1:0]     sum_q, sum_d;

  // One-hot of the contributing PE; out-of-range sources map to no bit.
  always_comb begin
    src_oh_s = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      src_oh_s[i] = (src_i == SRC_W'(i));
    end
  end

  assign dup_o  = |(mask_q & src_oh_s);
  assign full_o = add_en_i && ((mask_q | src_oh_s) == {NUM_PE{1'b1}});
  assign sum_o  = sum_q + SW'(psum_i);

  // Next state: clear wins so a completing add leaves the slot empty.
  always_comb begin
    sum_d  = sum_q;
    mask_d = mask_q;
    if (clear_i) begin
      sum_d  = '0;
      mask_d = '0;
    end else if (add_en_i) begin
      sum_d  = sum_o;
      mask_d = mask_q | src_oh_s;
    end else begin
      sum_d  = sum_q;
      mask_d = mask_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      mask_q <= '0;
    end else begin
      sum_q  <= sum_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects PE partial-sum packets per output column and emits one saturated
// pixel per completed column over a single-entry valid/ready output register.
module psum_collector
  import pe_pkg::*;
#(
  parameter int                PWIDTH   = 47,
  parameter int                PSWIDTH  = 16,
  parameter int                NUM_PE   = 3,
  parameter int                OUT_COLS = 3,
  parameter int                OWIDTH   = 8,
  parameter logic [DEST_W-1:0] MY_ADDR  = COLLECTOR_ADDR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PWIDTH-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OWIDTH-1:0]           out_pix,
  output logic [$clog2(OUT_COLS)-1:0] out_col,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        dup_err,
  output logic [7:0]                  drop_cnt
);

  localparam int CW = $clog2(OUT_COLS);
  localparam int SW = PSWIDTH + $clog2(NUM_PE) + 1;

  function automatic logic [OWIDTH-1:0] sat_pix(input logic [SW-1:0] s);
    if (s > SW'({OWIDTH{1'b1}})) begin
      return {OWIDTH{1'b1}};
    end else begin
      return s[OWIDTH-1:0];
    end
  endfunction

  psum_pkt_t           pkt_s;
  logic                accept_s, bad_s, dup_s, add_ok_s, drop_s, done_any_s;
  logic [OUT_COLS-1:0] hit_s, dup_vec_s, full_vec_s, clear_s;
  logic [SW-1:0]       sum_arr_s [OUT_COLS];
  logic [SW-1:0]       sel_sum_s;
  logic [CW-1:0]       sel_col_s;

  logic              out_valid_q, out_valid_d;
  logic [OWIDTH-1:0] out_pix_q, out_pix_d;
  logic [CW-1:0]     out_col_q, out_col_d;
  logic              dup_err_q, dup_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  assign pkt_s    = unpack_pkt(in_data);
  assign in_ready = !(out_valid_q && !out_ready);
  assign accept_s = in_valid && in_ready;
  assign bad_s    = (pkt_s.dest != MY_ADDR) || (pkt_s.ptype != PKT_PSUM) ||
                    (pkt_s.src >= SRC_W'(NUM_PE)) || (pkt_s.col >= COL_W'(OUT_COLS));
  assign dup_s    = |(dup_vec_s & hit_s);
  assign add_ok_s = accept_s && !bad_s && !dup_s;
  assign drop_s   = accept_s && (bad_s || dup_s);

  for (genvar g = 0; g < OUT_COLS; g++) begin : g_slot
    assign hit_s[g] = (pkt_s.col == COL_W'(g));
    psum_col_slot #(
      .PSWIDTH (PSWIDTH),
      .NUM_PE  (NUM_PE),
      .SW      (SW)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .add_en_i (add_ok_s && hit_s[g]),
      .clear_i  (clear_s[g]),
      .src_i    (pkt_s.src),
      .psum_i   (in_data[PSWIDTH-1:0]),
      .full_o   (full_vec_s[g]),
      .dup_o    (dup_vec_s[g]),
      .sum_o    (sum_arr_s[g])
    );
  end

  // Pick the completing slot, lowest column first.
  always_comb begin
    done_any_s = 1'b0;
    sel_sum_s  = '0;
    sel_col_s  = '0;
    clear_s    = '0;
    for (int c = 0; c < OUT_COLS; c++) begin
      if (full_vec_s[c] && !done_any_s) begin
        done_any_s = 1'b1;
        sel_sum_s  = sum_arr_s[c];
        sel_col_s  = CW'(c);
        clear_s[c] = 1'b1;
      end else begin
        clear_s[c] = 1'b0;
      end
    end
  end

  // Output register and status counters next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_col_d   = out_col_q;
    if (done_any_s) begin
      out_valid_d = 1'b1;
      out_pix_d   = sat_pix(sel_sum_s);
      out_col_d   = sel_col_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    dup_err_d = dup_err_q | (accept_s && !bad_s && dup_s);
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_col_q   <= '0;
      dup_err_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_col_q   <= out_col_d;
      dup_err_q   <= dup_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_col   = out_col_q;
  assign dup_err   = dup_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: a column-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_psum_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [46:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_pix;
  logic [1:0]  out_col;
  logic        out_valid;
  logic        out_ready;
  logic        dup_err;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  psum_collector #(
    .PWIDTH(47), .PSWIDTH(16), .NUM_PE(3), .OUT_COLS(3), .OWIDTH(8), .MY_ADDR(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_pix(out_pix), .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .dup_err(dup_err), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int got_pix[$];
  int got_col[$];
  int got_cyc[$];

  // Reference model state: per-column sums and contributor sets, one output slot.
  int m_sum[3];
  bit m_mask[3][3];
  bit m_valid;
  int m_pix, m_col, m_drop;
  bit m_dup;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      m_sum[c] = 0;
      for (int s = 0; s < 3; s++) m_mask[c][s] = 1'b0;
    end
    m_valid = 1'b0; m_pix = 0; m_col = 0; m_drop = 0; m_dup = 1'b0;
  endtask

  task automatic m_step();
    bit rdy, xfer, done;
    int dest, src, typ, col, ps;
    rdy  = !(m_valid && !out_ready);
    xfer = m_valid && out_ready;
    done = 1'b0;
    if (in_valid && rdy) begin
      dest = int'(in_data[46:43]); src = int'(in_data[42:39]); typ = int'(in_data[38:37]);
      col  = int'(in_data[20:16]); ps  = int'(in_data[15:0]);
      if (dest != 15 || typ != 2 || src >= 3 || col >= 3) begin
        if (m_drop < 255) m_drop++;
      end else if (m_mask[col][src]) begin
        m_dup = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        m_sum[col] += ps;
        m_mask[col][src] = 1'b1;
        if (m_mask[col][0] && m_mask[col][1] && m_mask[col][2]) begin
          done  = 1'b1;
          m_pix = (m_sum[col] > 255) ? 255 : m_sum[col];
          m_col = col;
          m_sum[col] = 0;
          for (int s = 0; s < 3; s++) m_mask[col][s] = 1'b0;
        end
      end
    end
    if (done) m_valid = 1'b1;
    else if (xfer) m_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", int'(in_ready), int'(!(m_valid && !out_ready)));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("dup_err", int'(dup_err), int'(m_dup));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      if (m_valid) begin
        chk("out_pix", int'(out_pix), m_pix);
        chk("out_col", int'(out_col), m_col);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && out_valid && out_ready) begin
        got_pix.push_back(int'(out_pix));
        got_col.push_back(int'(out_col));
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [3:0] dest, input logic [3:0] src, input logic [1:0] typ,
                      input logic [4:0] col, input logic [15:0] ps, output int acc_cyc);
    bit rdy;
    int n;
    n = 0;
    acc_cyc = -1;
    in_data  = {dest, src, typ, 16'h0000, col, ps};
    in_valid = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc = cyc;
        break;
      end
      n++;
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic psum(input logic [3:0] src, input logic [4:0] col, input logic [15:0] ps);
    int c;
    send(4'hF, src, 2'b10, col, ps, c);
  endtask

  task automatic chk_out(input string name, input int n, input int col, input int pix);
    chk({name, "_count"}, got_pix.size(), n);
    if (got_pix.size() >= n) begin
      chk({name, "_col"}, got_col[n-1], col);
      chk({name, "_pix"}, got_pix[n-1], pix);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_out_col", int'(out_col), 0);
    chk("rst_dup_err", int'(dup_err), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Complete column 1: 10+20+30, visible right after the third accept.
    psum(4'd0, 5'd1, 16'd10);
    psum(4'd1, 5'd1, 16'd20);
    chk("t1_not_yet", int'(out_valid), 0);
    psum(4'd2, 5'd1, 16'd30);
    chk("t1_latency_valid", int'(out_valid), 1);
    chk("t1_latency_pix", int'(out_pix), 60);
    chk("t1_latency_col", int'(out_col), 1);
    step();
    chk_out("t1", 1, 1, 60);

    // Saturation: 305 clips to 255.
    psum(4'd0, 5'd0, 16'd200);
    psum(4'd1, 5'd0, 16'd100);
    psum(4'd2, 5'd0, 16'd5);
    step();
    chk_out("t2", 2, 0, 255);

    // Duplicate from src 1 on column 2 is discarded.
    psum(4'd1, 5'd2, 16'd7);
    psum(4'd1, 5'd2, 16'd7);
    chk("t3_dup_err", int'(dup_err), 1);
    chk("t3_drop_cnt", int'(drop_cnt), 1);
    chk("t3_model_drop", m_drop, 1);
    psum(4'd0, 5'd2, 16'd1);
    psum(4'd2, 5'd2, 16'd2);
    step();
    chk_out("t3", 3, 2, 10);

    // Filtering: wrong dest, wrong type, bad column, bad source.
    send(4'h3, 4'd0, 2'b10, 5'd1, 16'd50, acc);
    send(4'hF, 4'd1, 2'b01, 5'd1, 16'd50, acc);
    send(4'hF, 4'd0, 2'b10, 5'd5, 16'd50, acc);
    send(4'hF, 4'd3, 2'b10, 5'd1, 16'd50, acc);
    chk("t4_drop_cnt", int'(drop_cnt), 5);
    step();
    chk("t4_no_output", got_pix.size(), 3);
    psum(4'd0, 5'd1, 16'd1);
    psum(4'd1, 5'd1, 16'd2);
    psum(4'd2, 5'd1, 16'd3);
    step();
    chk_out("t4", 4, 1, 6);

    // Backpressure: pixel waits, next packet held until the delivery edge.
    out_ready = 1'b0;
    psum(4'd0, 5'd0, 16'd1);
    psum(4'd1, 5'd0, 16'd2);
    psum(4'd2, 5'd0, 16'd3);
    chk("t5_in_ready_low", int'(in_ready), 0);
    chk("t5_pending_pix", int'(out_pix), 6);
    fork
      send(4'hF, 4'd0, 2'b10, 5'd1, 16'd9, acc);
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    chk_out("t5", 5, 0, 6);
    if (got_cyc.size() >= 5) chk("t5_same_edge", acc, got_cyc[4]);
    psum(4'd1, 5'd1, 16'd1);
    psum(4'd2, 5'd1, 16'd1);
    step();
    chk_out("t5b", 6, 1, 11);

    // Reset mid-frame discards column 0 partials.
    psum(4'd0, 5'd0, 16'd50);
    psum(4'd1, 5'd0, 16'd60);
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready", int'(in_ready), 1);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_out_pix", int'(out_pix), 0);
    chk("t6_out_col", int'(out_col), 0);
    chk("t6_dup_err", int'(dup_err), 0);
    chk("t6_drop_cnt", int'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    psum(4'd0, 5'd0, 16'd1);
    psum(4'd1, 5'd0, 16'd1);
    psum(4'd2, 5'd0, 16'd1);
    step();
    chk_out("t6", 7, 0, 3);
    chk("t6_dup_after", int'(dup_err), 0);
    chk("t6_drop_after", int'(drop_cnt), 0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
